// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store request at a time, configurable wait states,
// byte-lane stores and sign/zero-extended loads against a word-organised RAM.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic        lat_we_r;
    logic [31:0] lat_addr_r, lat_wdata_r;
    logic [2:0]  lat_size_r;
    logic        cur_we_s;
    logic [31:0] cur_addr_s, cur_wdata_s;
    logic [2:0]  cur_size_s;
    logic        accept_s, commit_s, cur_err_s;
    logic [ADDR_W-1:0] cur_idx_s;
    logic [3:0]  cur_be_s;
    logic [31:0] cur_wd_s, rd_word_s;
    logic [31:0] mem [0:(2**ADDR_W)-1];

    function automatic logic req_error(input logic we, input logic [31:0] addr, input logic [2:0] size);
        logic bad_size, misalign, out_of_range;
        if (we) begin
            bad_size = !(size == 3'b000 || size == 3'b001 || size == 3'b010);
        end else begin
            bad_size = !(size == 3'b000 || size == 3'b001 || size == 3'b010 ||
                         size == 3'b100 || size == 3'b101);
        end
        misalign = ((size == 3'b001 || size == 3'b101) && addr[0]) ||
                   (size == 3'b010 && addr[1:0] != 2'b00);
        out_of_range = (addr >> (ADDR_W + 2)) != 32'd0;
        return bad_size || misalign || out_of_range;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] size);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] size);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << lane;
            3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    assign req_ready = (state_r == S_IDLE);
    assign rsp_valid = (state_r == S_RESP);
    assign accept_s  = req_valid && (state_r == S_IDLE);
    assign commit_s  = (state_next_s == S_RESP) && (state_r != S_RESP);

    // With zero wait states the commit edge is the accept edge, so use the live request then
    always_comb begin
        cur_we_s    = lat_we_r;
        cur_addr_s  = lat_addr_r;
        cur_wdata_s = lat_wdata_r;
        cur_size_s  = lat_size_r;
        if (state_r == S_IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
            cur_size_s  = req_size;
        end else begin
            cur_we_s    = lat_we_r;
        end
    end

    // Decode of the request being committed: error, word index, lanes and replicated data
    always_comb begin
        cur_err_s = req_error(cur_we_s, cur_addr_s, cur_size_s);
        cur_idx_s = cur_addr_s[ADDR_W+1:2];
        cur_be_s  = store_be(cur_addr_s[1:0], cur_size_s);
        rd_word_s = mem[cur_idx_s];
        case (cur_size_s)
            3'b000:  cur_wd_s = {4{cur_wdata_s[7:0]}};
            3'b001:  cur_wd_s = {2{cur_wdata_s[15:0]}};
            default: cur_wd_s = cur_wdata_s;
        endcase
    end

    // Next-state logic for IDLE -> (WAIT) -> RESP -> IDLE
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next_s = S_RESP;
                    end else begin
                        state_next_s = S_WAIT;
                        cnt_next_s   = 4'(WAIT_CYCLES);
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, request latch and registered response
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= 4'd0;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
            lat_size_r  <= 3'd0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                lat_we_r    <= req_we;
                lat_addr_r  <= req_addr;
                lat_wdata_r <= req_wdata;
                lat_size_r  <= req_size;
            end
            if (commit_s) begin
                rsp_err   <= cur_err_s;
                rsp_rdata <= (cur_we_s || cur_err_s) ? 32'd0
                             : load_extend(rd_word_s, cur_addr_s[1:0], cur_size_s);
            end
        end
    end

    // RAM is not reset; a store pending when reset hits is simply dropped
    always_ff @(posedge clk) begin
        if (reset_n && commit_s && cur_we_s && !cur_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be_s[i]) begin
                    mem[cur_idx_s][8*i +: 8] <= cur_wd_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus backpressure and mid-transaction reset.
module tb_data_mem_responder;

    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_size = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_size  = v.size;
        req_valid = 1'b1;
    endtask

    // Issue one request, wait (bounded) for its response, handshake it
    task automatic do_req(input vec_t v, input string name);
        int n;
        int lat;
        @(negedge clk);
        drive(v);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, " accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, " ready_low"}, 32'(req_ready), 32'(WAITC == 0 ? 0 : 0));
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(WAITC));
        chk({name, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({name, " err"}, 32'(rsp_err), 32'(v.exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t v, v2;
        logic [31:0] held;
        int n;

        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h11,  32'h00000080, 3'b000, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b100, 32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b1, 32'h12,  32'h00008001, 3'b001, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, 32'h12,  32'h0,        3'b101, 32'h00008001, 1'b0});
        vecs.push_back('{1'b0, 32'h13,  32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h11,  32'h00001234, 3'b001, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'h800180EF, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b000, 32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b001, 32'hFFFF80EF, 1'b0});
        vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b101, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h14,  32'h12345678, 3'b011, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h14,  32'h0,        3'b110, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h80000010, 32'hFFFFFFFF, 3'b010, 32'h0,   1'b1});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'h800180EF, 1'b0});
        vecs.push_back('{1'b1, 32'h3FC, 32'h11223344, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h3FF, 32'hFFFFFFAA, 3'b000, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h3FC, 32'h0,        3'b010, 32'hAA223344, 1'b0});
        vecs.push_back('{1'b0, 32'h3FE, 32'h0,        3'b100, 32'h00000022, 1'b0});
        vecs.push_back('{1'b0, 32'h3FD, 32'h0,        3'b000, 32'h00000033, 1'b0});
        vecs.push_back('{1'b1, 32'h20,  32'h5A5A5A5A, 3'b010, 32'h0,        1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a second request waits
        v  = '{1'b0, 32'h10,  32'h0, 3'b010, 32'h800180EF, 1'b0};
        v2 = '{1'b0, 32'h3FC, 32'h0, 3'b010, 32'hAA223344, 1'b0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        @(negedge clk);
        drive(v2);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp first rdata", rsp_rdata, v.exp_rdata);
        held = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp rsp_valid held", 32'(rsp_valid), 32'd1);
            chk("bp rdata held", rsp_rdata, 32'h800180EF);
            chk("bp req_ready low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp idle after handshake", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp second latency", 32'(n), 32'(WAITC));
        chk("bp second rdata", rsp_rdata, v2.exp_rdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during WAIT of a store: store must be dropped
        v = '{1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst in wait state", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        reset_n = 1'b1;
        do_req('{1'b0, 32'h20, 32'h0, 3'b010, 32'h5A5A5A5A, 1'b0}, "rst load old");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
